approx_error_monitor: RTL and testbench

- Sequential sink for approximate-adder result streams: accepts (exact, approximate) sum pairs over a valid/ready handshake and accumulates error metrics over a programmable sample window.
- Sits downstream of an approximate adder chain and its exact reference adder in characterisation benches and on-chip self-test. It reports error count, maximum error distance and summed error distance.

---
 rtl/approx_error_monitor.sv | 117 +++++++++++
 tb/tb_approx_error_monitor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/approx_error_monitor.sv
// approx_error_monitor: collects error statistics for (exact, approximate) sum
// pairs over a programmable sample window. A two-stage pipeline (|diff|, then
// accumulate) sustains one sample per cycle.
module approx_error_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [CNT_W-1:0] window,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH:0]   exactSum,
  input  logic [WIDTH:0]   approxSum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sampleCount,
  output logic [CNT_W-1:0] errCount,
  output logic [WIDTH:0]   maxErr,
  output logic [ACC_W-1:0] sumErr
);

  // Saturating add runs one bit wider than the larger operand so the clamp
  // test never sees a wrapped result.
  localparam int SW = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;
  localparam logic [SW-1:0] ACC_MAX = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] win_q, acc_q;
  logic [WIDTH:0]   diff_q, diff_d;
  logic             s1_vld_q;
  logic [CNT_W-1:0] sampleCount_q, errCount_q;
  logic [WIDTH:0]   maxErr_q;
  logic [ACC_W-1:0] sumErr_q;
  logic [SW-1:0]    sum_ext;
  logic             xfer, clr;

  assign inReady = (state_q == S_RUN) && (acc_q < win_q);
  assign xfer    = inValid && inReady;
  assign clr     = (state_q == S_IDLE) && start;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign diff_d  = (exactSum >= approxSum) ? (exactSum - approxSum) : (approxSum - exactSum);
  assign sum_ext = SW'(sumErr_q) + SW'(diff_q);

  assign sampleCount = sampleCount_q;
  assign errCount    = errCount_q;
  assign maxErr      = maxErr_q;
  assign sumErr      = sumErr_q;

  // Next-state logic for the window sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (window != '0) ? S_RUN : S_DONE;
      S_RUN:   if (xfer && ((acc_q + CNT_W'(1)) == win_q)) state_d = S_DRAIN;
      // No transfers happen here; stage 1 holds the last sample and retires it
      // into the statistics on this edge, so they are final in DONE.
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, latched window and accepted-sample counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        win_q <= window;
        acc_q <= '0;
      end else if (xfer) begin
        acc_q <= acc_q + CNT_W'(1);
      end
    end
  end

  // Stage 1: absolute error of the accepted pair.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1_vld_q <= 1'b0;
      diff_q   <= '0;
    end else begin
      s1_vld_q <= xfer;
      if (xfer) diff_q <= diff_d;
    end
  end

  // Stage 2: fold the stage-1 error into the window statistics.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sampleCount_q <= '0;
      errCount_q    <= '0;
      maxErr_q      <= '0;
      sumErr_q      <= '0;
    end else if (clr) begin
      sampleCount_q <= '0;
      errCount_q    <= '0;
      maxErr_q      <= '0;
      sumErr_q      <= '0;
    end else if (s1_vld_q) begin
      sampleCount_q <= sampleCount_q + CNT_W'(1);
      errCount_q    <= errCount_q + CNT_W'(diff_q != '0);
      if (diff_q > maxErr_q) maxErr_q <= diff_q;
      sumErr_q      <= (sum_ext > ACC_MAX) ? ACC_MAX[ACC_W-1:0] : sum_ext[ACC_W-1:0];
    end
  end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Bench for approx_error_monitor: two instances (ACC_W=32 and ACC_W=8) share
// stimulus; expectations come from a list-based model of the accepted pairs.
module tb_approx_error_monitor;
  logic        clk = 1'b0, rstN = 1'b0, start = 1'b0, inValid = 1'b0;
  logic [15:0] window = '0;
  logic [8:0]  exactSum = '0, approxSum = '0;

  logic        inReadyA, busyA, doneA, inReadyB, busyB, doneB;
  logic [15:0] scA, ecA, scB, ecB;
  logic [8:0]  meA, meB;
  logic [31:0] seA;
  logic [7:0]  seB;

  int checks = 0, failures = 0;
  int ex_q[$], ap_q[$];
  bit vpat[$];

  approx_error_monitor #(.WIDTH(8), .CNT_W(16), .ACC_W(32)) dutA (
    .clk(clk), .rstN(rstN), .start(start), .window(window), .inValid(inValid),
    .inReady(inReadyA), .exactSum(exactSum), .approxSum(approxSum), .busy(busyA),
    .done(doneA), .sampleCount(scA), .errCount(ecA), .maxErr(meA), .sumErr(seA));

  approx_error_monitor #(.WIDTH(8), .CNT_W(16), .ACC_W(8)) dutB (
    .clk(clk), .rstN(rstN), .start(start), .window(window), .inValid(inValid),
    .inReady(inReadyB), .exactSum(exactSum), .approxSum(approxSum), .busy(busyB),
    .done(doneB), .sampleCount(scB), .errCount(ecB), .maxErr(meB), .sumErr(seB));

  always #5 clk = ~clk;

  // Reference statistics over the first n listed pairs.
  function automatic void model(input int n, output longint cnt, output longint err,
                                output longint mx, output longint sm);
    longint d;
    cnt = 0; err = 0; mx = 0; sm = 0;
    for (int i = 0; i < n; i++) begin
      d = (ex_q[i] > ap_q[i]) ? ex_q[i] - ap_q[i] : ap_q[i] - ex_q[i];
      cnt++;
      if (d != 0) err++;
      if (d > mx) mx = d;
      sm += d;
    end
  endfunction

  // mode: 0 = inValid always high, 1 = vpat sequence, 2 = random inValid.
  // poke: pulse start (with another window value) during RUN and during DONE.
  task automatic run_window(input int win, input int mode, input bit poke);
    int acc = 0, last = -2, vi = 0, c, nsc;
    int xc[$];
    bit v, rdy, dexp, bexp, finished = 0;
    longint cnt, err, mx, sm, smA, smB;
    start = 1'b1; window = 16'(win); inValid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (c = 0; c < 400; c++) begin
      rdy  = (acc < win);
      dexp = (acc == win) && (c == last + 2);
      bexp = !((acc == win) && (c >= last + 3));
      nsc = 0;
      foreach (xc[k]) if (xc[k] <= c - 2) nsc++;
      checks++; if (inReadyA !== rdy || inReadyB !== rdy) begin failures++;
        $display("FAIL inReady c=%0d got=%b/%b exp=%b", c, inReadyA, inReadyB, rdy); end
      checks++; if (doneA !== dexp || doneB !== dexp) begin failures++;
        $display("FAIL done c=%0d got=%b/%b exp=%b", c, doneA, doneB, dexp); end
      checks++; if (busyA !== bexp || busyB !== bexp) begin failures++;
        $display("FAIL busy c=%0d got=%b/%b exp=%b", c, busyA, busyB, bexp); end
      checks++; if (scA !== 16'(nsc)) begin failures++;
        $display("FAIL sampleCount_latency c=%0d got=%0d exp=%0d", c, scA, nsc); end
      if (dexp) begin
        model(win, cnt, err, mx, sm);
        smA = (sm > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : sm;
        smB = (sm > 255) ? 255 : sm;
        checks++; if (scA !== 16'(cnt) || scB !== 16'(cnt)) begin failures++;
          $display("FAIL sampleCount got=%0d/%0d exp=%0d", scA, scB, cnt); end
        checks++; if (ecA !== 16'(err) || ecB !== 16'(err)) begin failures++;
          $display("FAIL errCount got=%0d/%0d exp=%0d", ecA, ecB, err); end
        checks++; if (meA !== 9'(mx) || meB !== 9'(mx)) begin failures++;
          $display("FAIL maxErr got=%0d/%0d exp=%0d", meA, meB, mx); end
        checks++; if (seA !== 32'(smA)) begin failures++;
          $display("FAIL sumErr32 got=%0d exp=%0d", seA, smA); end
        checks++; if (seB !== 8'(smB)) begin failures++;
          $display("FAIL sumErr8 got=%0d exp=%0d", seB, smB); end
      end
      if ((acc == win) && (c == last + 3)) begin finished = 1; break; end
      case (mode)
        0: v = 1'b1;
        1: v = (vi < vpat.size()) ? vpat[vi] : 1'b0;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      vi++;
      inValid = v;
      if (v && acc < ex_q.size()) begin
        exactSum = 9'(ex_q[acc]); approxSum = 9'(ap_q[acc]);
      end else begin
        exactSum = 9'($urandom); approxSum = 9'($urandom);
      end
      if (poke && (c == 1 || dexp)) begin start = 1'b1; window = 16'd9; end
      else start = 1'b0;
      if (v && rdy) begin
        xc.push_back(c); acc++;
        if (acc == win) last = c;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; inValid = 1'b0;
    if (!finished) begin failures++;
      $display("FAIL window_timeout win=%0d accepted=%0d", win, acc); end
  endtask

  task automatic fill_random(input int n);
    int e;
    ex_q.delete(); ap_q.delete();
    for (int i = 0; i < n; i++) begin
      e = $urandom_range(0, 511);
      ex_q.push_back(e);
      ap_q.push_back(($urandom_range(0, 3) == 0) ? e : $urandom_range(0, 511));
    end
  endtask

  task automatic test_reset;
    rstN = 1'b0;
    #3;
    checks++; if ({inReadyA, busyA, doneA} !== 3'b000) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=000", {inReadyA, busyA, doneA}); end
    checks++; if (scA !== 0 || ecA !== 0 || meA !== 0 || seA !== 0 || seB !== 0) begin failures++;
      $display("FAIL reset_stats got=%0d,%0d,%0d,%0d exp=0", scA, ecA, meA, seA); end
    #9 rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    ex_q = '{100, 200, 37, 511};
    ap_q = '{100, 196, 45, 511};
    run_window(4, 0, 0);
    checks++; if (scA !== 16'd4 || ecA !== 16'd2 || meA !== 9'd8 || seA !== 32'd12) begin
      failures++;
      $display("FAIL basic_stats got=%0d,%0d,%0d,%0d exp=4,2,8,12", scA, ecA, meA, seA); end
  endtask

  task automatic test_stall;
    fill_random(3);
    vpat = '{1, 0, 0, 1, 0, 1};
    run_window(3, 1, 0);
  endtask

  task automatic test_zero_window;
    fill_random(2);
    run_window(0, 0, 0);
  endtask

  task automatic test_saturation;
    ex_q = '{300, 0, 50};
    ap_q = '{100, 100, 0};
    run_window(3, 0, 0);
    checks++; if (seB !== 8'd255 || meB !== 9'd200 || ecB !== 16'd3 || seA !== 32'd350) begin
      failures++;
      $display("FAIL saturation got=%0d,%0d,%0d,%0d exp=255,200,3,350", seB, meB, ecB, seA); end
  endtask

  task automatic test_start_ignored;
    fill_random(6);
    run_window(6, 0, 1);
    fill_random(5);
    run_window(5, 2, 0);
  endtask

  task automatic test_back_to_back;
    fill_random(20);
    run_window(20, 0, 0);
    fill_random(17);
    run_window(17, 2, 0);
  endtask

  task automatic test_reset_midrun;
    fill_random(10);
    start = 1'b1; window = 16'd10;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1; exactSum = 9'(ex_q[i]); approxSum = 9'(ap_q[i]);
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    @(posedge clk); #1;
    #2 rstN = 1'b0;
    #1;
    checks++; if ({inReadyA, busyA, doneA, inReadyB, busyB, doneB} !== 6'b0) begin failures++;
      $display("FAIL midrun_reset_ctrl got=%b exp=0", {inReadyA, busyA, doneA}); end
    checks++; if (scA !== 0 || ecA !== 0 || meA !== 0 || seA !== 0 || seB !== 0) begin failures++;
      $display("FAIL midrun_reset_stats got=%0d,%0d,%0d,%0d exp=0", scA, ecA, meA, seA); end
    @(posedge clk); #3 rstN = 1'b1;
    inValid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({inReadyA, busyA, doneA} !== 3'b000 || scA !== 0) begin failures++;
      $display("FAIL post_reset_idle got=%b sc=%0d exp=000 sc=0", {inReadyA, busyA, doneA}, scA); end
    inValid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_zero_window;
    test_saturation;
    test_start_ignored;
    test_back_to_back;
    test_reset_midrun;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
